// File: rtl/rv_trace_buf_pkg.sv
// Shared types for the retired-instruction trace buffer: capture modes, FSM states and the
// stored entry layout.
package rv_trace_pkg;

  localparam int unsigned PcW   = 30;
  localparam int unsigned XlenW = 32;

  typedef enum logic [1:0] {
    ModeOff  = 2'd0,
    ModeFill = 2'd1,
    ModeRing = 2'd2,
    ModeTrig = 2'd3
  } trace_mode_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StPost    = 2'd2,
    StFrozen  = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [PcW-1:0]   pc;
    logic [XlenW-1:0] instr;
    logic             rd_we;
    logic [XlenW-1:0] rd_data;
  } trace_entry_t;

  // rd_data is zeroed for non-writing instructions so stale bus values never reach the store.
  function automatic trace_entry_t make_entry(logic [PcW-1:0] pc, logic [XlenW-1:0] instr,
                                              logic rd_we, logic [XlenW-1:0] rd_data);
    trace_entry_t e;
    e.pc      = pc;
    e.instr   = instr;
    e.rd_we   = rd_we;
    e.rd_data = rd_we ? rd_data : '0;
    return e;
  endfunction

endpackage

// File: rtl/rv_trace_buf_if.sv
// Retire capture and drain port of the trace buffer; slave is the buffer side.
interface rv_trace_buf_if;

  logic        i_ret_valid;
  logic [29:0] i_ret_pc;
  logic [31:0] i_ret_instr;
  logic        i_ret_rd_we;
  logic [31:0] i_ret_rd_data;

  logic        o_rd_valid;
  logic        i_rd_ready;
  logic [29:0] o_rd_pc;
  logic [31:0] o_rd_instr;
  logic        o_rd_rd_we;
  logic [31:0] o_rd_rd_data;

  modport slave (
    input  i_ret_valid, i_ret_pc, i_ret_instr, i_ret_rd_we, i_ret_rd_data, i_rd_ready,
    output o_rd_valid, o_rd_pc, o_rd_instr, o_rd_rd_we, o_rd_rd_data
  );

  modport master (
    output i_ret_valid, i_ret_pc, i_ret_instr, i_ret_rd_we, i_ret_rd_data, i_rd_ready,
    input  o_rd_valid, o_rd_pc, o_rd_instr, o_rd_rd_we, o_rd_rd_data
  );

endinterface

// File: rtl/rv_trace_fifo.sv
// Circular entry store with an overwrite-oldest option; clear has priority over push/pop.
module rv_trace_fifo
  import rv_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_overwrite,
  input  trace_entry_t             i_entry,
  output trace_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  trace_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q;
  logic           do_push, do_pop;

  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);

  // An overwrite retires the oldest entry in the same cycle as the new one lands.
  assign do_push = i_push & (~o_full | i_pop | i_overwrite);
  assign do_pop  = (i_pop & ~o_empty) | (do_push & i_overwrite);

  always_ff @(posedge i_clk) begin
    if (do_push && !i_clear && !i_reset) begin
      mem[wr_q] <= i_entry;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign o_head  = mem[rd_q];
  assign o_count = cnt_q;

endmodule

// File: rtl/rv_trace_buf.sv
// Retired-instruction trace buffer: capture FSM, PC trigger, post-trigger counter and
// saturating drop counter around the circular store.
module rv_trace_buf
  import rv_trace_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8,
  parameter int unsigned DROP_W    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [1:0]             i_mode,
  input  logic                   i_arm,
  input  logic [29:0]            i_trig_pc,
  rv_trace_buf_if.slave          bus,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [DROP_W-1:0]      o_dropped,
  output logic [1:0]             o_state,
  output logic                   o_triggered
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  trace_state_e  state_q, state_d;
  trace_mode_e   mode_q;
  logic [CW-1:0] post_q, post_d;
  logic          trig_q, trig_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic          push, pop, overwrite, full, empty, trig_hit;
  trace_entry_t  wr_entry, head;

  assign push = bus.i_ret_valid & ~i_arm & ((state_q == StCapture) | (state_q == StPost));
  assign pop  = ~empty & bus.i_rd_ready & ~i_arm;
  assign overwrite = push & full & ~pop;
  assign trig_hit  = push & (mode_q == ModeTrig) & (state_q == StCapture) &
                     (bus.i_ret_pc == i_trig_pc);

  assign wr_entry = make_entry(bus.i_ret_pc, bus.i_ret_instr, bus.i_ret_rd_we, bus.i_ret_rd_data);

  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    trig_d  = trig_q;
    drop_d  = drop_q;
    if (i_arm) begin
      state_d = (trace_mode_e'(i_mode) == ModeOff) ? StIdle : StCapture;
      post_d  = '0;
      trig_d  = 1'b0;
      drop_d  = '0;
    end else begin
      if (overwrite && drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
      if (push && state_q == StCapture) begin
        if (mode_q == ModeFill && o_count == CW'(DEPTH - 1) && !pop) begin
          state_d = StFrozen;
        end else if (trig_hit) begin
          trig_d  = 1'b1;
          post_d  = CW'(POST_TRIG);
          state_d = (POST_TRIG == 0) ? StFrozen : StPost;
        end
      end else if (push && state_q == StPost) begin
        post_d = post_q - 1'b1;
        if (post_q == CW'(1)) begin
          state_d = StFrozen;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      mode_q  <= ModeOff;
      post_q  <= '0;
      trig_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
      trig_q  <= trig_d;
      drop_q  <= drop_d;
      if (i_arm) begin
        mode_q <= trace_mode_e'(i_mode);
      end
    end
  end

  rv_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (i_arm),
    .i_push      (push),
    .i_pop       (pop),
    .i_overwrite (overwrite),
    .i_entry     (wr_entry),
    .o_head      (head),
    .o_count     (o_count),
    .o_full      (full),
    .o_empty     (empty)
  );

  assign bus.o_rd_valid   = ~empty;
  assign bus.o_rd_pc      = head.pc;
  assign bus.o_rd_instr   = head.instr;
  assign bus.o_rd_rd_we   = head.rd_we;
  assign bus.o_rd_rd_data = head.rd_data;

  assign o_dropped   = drop_q;
  assign o_state     = state_q;
  assign o_triggered = trig_q;

endmodule

// File: tb/tb_rv_trace_buf.sv
// Directed plus randomized bench for rv_trace_buf against a queue-based reference model.
module tb_rv_trace_buf;

  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 8;
  localparam int DROP_W    = 4;
  localparam int DROP_MAX  = (1 << DROP_W) - 1;

  logic        clk = 1'b0;
  logic        reset, arm;
  logic [1:0]  mode;
  logic [29:0] trig_pc;
  logic [4:0]  count;
  logic [DROP_W-1:0] dropped;
  logic [1:0]  state;
  logic        triggered;

  rv_trace_buf_if bus ();

  rv_trace_buf #(
    .DEPTH     (DEPTH),
    .POST_TRIG (POST_TRIG),
    .DROP_W    (DROP_W)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_mode      (mode),
    .i_arm       (arm),
    .i_trig_pc   (trig_pc),
    .bus         (bus.slave),
    .o_count     (count),
    .o_dropped   (dropped),
    .o_state     (state),
    .o_triggered (triggered)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   m_state, m_mode, m_drop, m_post;
  bit   m_trig;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   seen_trig_entry;
  logic [29:0] last_pc;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("count", 32'(count), q.size());
    check("dropped", 32'(dropped), m_drop);
    check("state", 32'(state), m_state);
    check("triggered", 32'(triggered), 32'(m_trig));
    check("rd_valid", 32'(bus.o_rd_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("head_pc", 32'(bus.o_rd_pc), 32'(q[0].pc));
      check("head_instr", bus.o_rd_instr, q[0].instr);
      check("head_we", 32'(bus.o_rd_rd_we), 32'(q[0].we));
      check("head_data", bus.o_rd_rd_data, q[0].data);
    end
  endtask

  // Reference: the store is a queue; full means DEPTH elements.
  task automatic model_edge();
    ent_t e;
    bit   push, pop;
    if (reset) begin
      q.delete();
      m_state = 0; m_mode = 0; m_drop = 0; m_post = 0; m_trig = 0;
    end else if (arm) begin
      q.delete();
      m_mode  = int'(mode);
      m_state = (mode == 2'd0) ? 0 : 1;
      m_drop  = 0; m_post = 0; m_trig = 0;
    end else begin
      pop  = bus.i_rd_ready && q.size() > 0;
      push = bus.i_ret_valid && (m_state == 1 || m_state == 2);
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc    = bus.i_ret_pc;
        e.instr = bus.i_ret_instr;
        e.we    = bus.i_ret_rd_we;
        e.data  = bus.i_ret_rd_we ? bus.i_ret_rd_data : 32'd0;
        if (q.size() == DEPTH) begin
          void'(q.pop_front());
          if (m_drop < DROP_MAX) m_drop++;
        end
        q.push_back(e);
        if (m_state == 1) begin
          if (m_mode == 1 && q.size() == DEPTH) m_state = 3;
          else if (m_mode == 3 && e.pc == trig_pc) begin
            m_trig = 1;
            m_post = POST_TRIG;
            m_state = (POST_TRIG == 0) ? 3 : 2;
          end
        end else if (m_state == 2) begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
      end
    end
  endtask

  task automatic step(bit rst, bit a, logic [1:0] md, bit v, logic [29:0] pc, bit rdy);
    reset             = rst;
    arm               = a;
    mode              = md;
    bus.i_ret_valid   = v;
    bus.i_ret_pc      = pc;
    bus.i_ret_instr   = $urandom;
    bus.i_ret_rd_we   = 1'($urandom);
    bus.i_ret_rd_data = $urandom;
    bus.i_rd_ready    = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    trig_pc = 30'h0;
    step(1, 0, 2'd0, 0, 30'h0, 0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_count", 32'(count), 32'd0);

    // Fill-stop
    step(0, 1, 2'd1, 0, 30'h0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 2'd0, 1, 30'h100 + 30'(i), 0);
    check("fill_state", 32'(state), 32'd3);
    check("fill_count", 32'(count), 32'd16);
    check("fill_dropped", 32'(dropped), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("fill_drain_pc", 32'(bus.o_rd_pc), 32'h100 + 32'(i));
      step(0, 0, 2'd0, 1, 30'h0, 1);
    end
    check("fill_empty", 32'(bus.o_rd_valid), 32'd0);

    // Ring overwrite
    step(0, 1, 2'd2, 0, 30'h0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 2'd0, 1, 30'h200 + 30'(i), 0);
    check("ring_count", 32'(count), 32'd16);
    check("ring_dropped", 32'(dropped), 32'd4);
    check("ring_head", 32'(bus.o_rd_pc), 32'h204);

    // Full with simultaneous pop
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 2'd0, 1, 30'h400 + 30'(i), 1);
      check("fullpop_count", 32'(count), 32'd16);
      check("fullpop_dropped", 32'(dropped), 32'd4);
    end

    // Re-arm with a same-cycle retire
    step(0, 1, 2'd2, 1, 30'h500, 1);
    check("rearm_count", 32'(count), 32'd0);
    check("rearm_dropped", 32'(dropped), 32'd0);

    // PC trigger
    trig_pc = 30'h305;
    step(0, 1, 2'd3, 0, 30'h0, 0);
    for (int i = 0; i < 32; i++) step(0, 0, 2'd0, 1, 30'h300 + 30'(i), 0);
    check("trig_state", 32'(state), 32'd3);
    check("trig_flag", 32'(triggered), 32'd1);
    check("trig_count", 32'(count), 32'd14);
    seen_trig_entry = 0;
    last_pc = '0;
    for (int i = 0; i < 14; i++) begin
      if (bus.o_rd_pc == 30'h305) seen_trig_entry = 1;
      last_pc = bus.o_rd_pc;
      step(0, 0, 2'd0, 0, 30'h0, 1);
    end
    check("trig_entry_seen", 32'(seen_trig_entry), 32'd1);
    check("trig_last_pc", 32'(last_pc), 32'h30D);

    // Drop counter saturation
    step(0, 1, 2'd2, 0, 30'h0, 0);
    for (int i = 0; i < 56; i++) step(0, 0, 2'd0, 1, 30'h600 + 30'(i), 0);
    check("drop_sat", 32'(dropped), 32'(DROP_MAX));

    // Mid-capture reset
    step(1, 0, 2'd0, 1, 30'h700, 0);
    check("midreset_count", 32'(count), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bit rst_r, arm_r;
      rst_r = ($urandom_range(0, 499) == 0);
      arm_r = ($urandom_range(0, 39) == 0);
      if (arm_r) trig_pc = 30'($urandom_range(0, 31));
      step(rst_r, arm_r, 2'($urandom), $urandom_range(0, 9) < 7,
           30'($urandom_range(0, 31)), $urandom_range(0, 9) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
